// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO read side: depth, drain FSM encoding and
// the skid-buffer credit check used to throttle FIFO pops.
package fifo_stream_reader_pkg;

   localparam int FIFO_ADDR_W = 3;
   localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;
   localparam int SKID_DEPTH  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // A new read may only be issued if its word is guaranteed a skid slot.
   function automatic logic has_credit(input logic [1:0] buf_cnt,
                                       input logic       in_flight,
                                       input logic       pop);
      logic [2:0] occ;
      occ = {1'b0, buf_cnt} + {2'b00, in_flight} - {2'b00, pop};
      return occ < 3'(SKID_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// 2-entry in-order valid/ready buffer; outputs come straight from registers.
module stream_skid_buf #(
   parameter int dataWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [dataWidth-1:0] data_i,
   input  logic                 pop_i,
   output logic [dataWidth-1:0] data_o,
   output logic                 valid_o,
   output logic [1:0]           count_o
);

   logic [dataWidth-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]           count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (count_q == 2'd0) head_d = data_i;
            else                 tail_d = data_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged; the new word lands behind whatever remains.
            if (count_q == 2'd1) head_d = data_i;
            else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign data_o  = head_q;
   assign valid_o = (count_q != 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain controller: pops a programmed word count from the FIFO
// under skid-buffer credit and streams it out on valid/ready.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int dataWidth = 8,
   parameter int addrWidth = FIFO_ADDR_W,
   parameter int lenWidth  = addrWidth + 2
) (
   input  logic                 clkIn,
   input  logic                 rstIn,
   input  logic                 startIn,
   input  logic [lenWidth-1:0]  lengthIn,
   input  logic [dataWidth-1:0] fifoDataIn,
   input  logic                 fifoEmptyIn,
   output logic                 fifoReadEnableOut,
   output logic [dataWidth-1:0] outDataOut,
   output logic                 outValidOut,
   input  logic                 outReadyIn,
   output logic                 busyOut,
   output logic                 doneOut,
   output logic [lenWidth-1:0]  wordCountOut
);

   state_e              state_q;
   logic                busy_q, done_q, inFlight_q;
   logic [lenWidth-1:0] len_q, issued_q, issued_d, cnt_q, cnt_d;
   logic [1:0]          bufCount;
   logic                pop, rd;

   assign pop = outValidOut & outReadyIn;
   // Gated by reset so a pop is never lost while the block is being cleared.
   assign rd  = rstIn & (state_q == ST_DRAIN) & ~fifoEmptyIn &
                (issued_q < len_q) & has_credit(bufCount, inFlight_q, pop);

   assign issued_d = rd  ? issued_q + lenWidth'(1) : issued_q;
   assign cnt_d    = pop ? cnt_q + lenWidth'(1)    : cnt_q;

   always_ff @(posedge clkIn) begin
      if (!rstIn) inFlight_q <= 1'b0;
      else        inFlight_q <= rd;
   end

   always_ff @(posedge clkIn) begin
      if (!rstIn) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         len_q    <= '0;
         issued_q <= '0;
         cnt_q    <= '0;
      end else begin
         done_q   <= 1'b0;
         issued_q <= issued_d;
         cnt_q    <= cnt_d;
         case (state_q)
            ST_IDLE: if (startIn) begin
               len_q    <= lengthIn;
               issued_q <= '0;
               cnt_q    <= '0;
               if (lengthIn == '0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_DRAIN;
                  busy_q  <= 1'b1;
               end
            end
            ST_DRAIN: if (pop && cnt_d == len_q) begin
               state_q <= ST_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   stream_skid_buf #(.dataWidth(dataWidth)) u_skid (
      .clk_i   (clkIn),
      .rst_ni  (rstIn),
      .push_i  (inFlight_q),
      .data_i  (fifoDataIn),
      .pop_i   (pop),
      .data_o  (outDataOut),
      .valid_o (outValidOut),
      .count_o (bufCount)
   );

   assign fifoReadEnableOut = rd;
   assign busyOut           = busy_q;
   assign doneOut           = done_q;
   assign wordCountOut      = cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, scoreboard of written
// words, a cycle table for the full drain, and scripted corner sequences.
module tb_fifo_stream_reader;

   logic       clkIn = 1'b0;
   logic       rstIn, startIn, fifoEmptyIn, outReadyIn;
   logic [4:0] lengthIn;
   logic [7:0] fifoDataIn;
   logic       fifoReadEnableOut, outValidOut, busyOut, doneOut;
   logic [7:0] outDataOut;
   logic [4:0] wordCountOut;

   fifo_stream_reader dut (
      .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .lengthIn(lengthIn),
      .fifoDataIn(fifoDataIn), .fifoEmptyIn(fifoEmptyIn),
      .fifoReadEnableOut(fifoReadEnableOut), .outDataOut(outDataOut),
      .outValidOut(outValidOut), .outReadyIn(outReadyIn), .busyOut(busyOut),
      .doneOut(doneOut), .wordCountOut(wordCountOut)
   );

   always #5 clkIn = ~clkIn;

   typedef struct {
      logic       start;
      logic [4:0] len;
      logic       ready;
      logic       erd, ev;
      logic [7:0] ed;
      logic       edone, ebusy;
      logic [4:0] ecnt;
   } vec_t;

   int         vectors = 0, misses = 0;
   logic [7:0] fifo[$];
   logic [7:0] exp_q[$];
   logic       s_valid, s_done, s_busy, s_rd;
   logic [7:0] s_data;
   logic [4:0] s_cnt;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   int         outst = 0, done_cnt = 0, reads_tot = 0;
   vec_t       tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         misses++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      fifo.push_back(w);
      exp_q.push_back(w);
      fifoEmptyIn = 1'b0;
   endtask

   // One clock: sample at negedge, run monitors, then update the FIFO model.
   task automatic cyc();
      logic rd, hs;
      @(negedge clkIn);
      s_valid = outValidOut; s_data = outDataOut; s_done = doneOut;
      s_busy = busyOut; s_cnt = wordCountOut; s_rd = fifoReadEnableOut;
      rd = s_rd;
      chk("rd_while_empty", {31'd0, s_rd & fifoEmptyIn}, 0);
      if (rstIn) begin
         if (prev_stall) begin
            chk("stall_valid", {31'd0, s_valid}, 1);
            chk("stall_data", {24'd0, s_data}, {24'd0, prev_data});
         end
         hs = s_valid & outReadyIn;
         if (hs) begin
            if (exp_q.size() == 0) begin
               vectors++; misses++;
               $display("FAIL sb_extra_word: got 0x%0h expected no word", s_data);
            end else chk("sb_data", {24'd0, s_data}, {24'd0, exp_q.pop_front()});
         end
         outst = outst + int'(rd) - int'(hs);
         chk("occupancy_le2", {31'd0, outst > 2}, 0);
         if (s_done) done_cnt++;
         if (rd) reads_tot++;
         prev_stall = s_valid & ~outReadyIn;
         prev_data  = s_data;
      end else begin
         outst = 0;
         prev_stall = 1'b0;
      end
      @(posedge clkIn);
      #1;
      if (rd && fifo.size() > 0) fifoDataIn = fifo.pop_front();
      fifoEmptyIn = (fifo.size() == 0);
      startIn = 1'b0;
   endtask

   task automatic run_until_done(input string name, input int budget);
      logic got;
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         cyc();
         if (s_done) got = 1'b1;
      end
      chk(name, {31'd0, got}, 1);
   endtask

   initial begin
      int d0, r0;
      logic got;
      for (int c = 0; c < 13; c++) begin
         tbl[c].start = (c == 0);
         tbl[c].len   = 5'd8;
         tbl[c].ready = 1'b1;
         tbl[c].erd   = (c >= 1 && c <= 8);
         tbl[c].ev    = (c >= 3 && c <= 10);
         tbl[c].ed    = tbl[c].ev ? 8'(c - 3) : 8'h00;
         tbl[c].edone = (c == 11);
         tbl[c].ebusy = (c >= 1 && c <= 10);
         tbl[c].ecnt  = (c < 3) ? 5'd0 : (c >= 11) ? 5'd8 : 5'(c - 3);
      end

      rstIn = 1'b0; startIn = 1'b0; lengthIn = '0; fifoDataIn = '0;
      fifoEmptyIn = 1'b1; outReadyIn = 1'b1;
      cyc(); cyc();
      rstIn = 1'b1;
      cyc();
      chk("rst_valid", {31'd0, s_valid}, 0);
      chk("rst_data",  {24'd0, s_data}, 0);
      chk("rst_busy",  {31'd0, s_busy}, 0);
      chk("rst_done",  {31'd0, s_done}, 0);
      chk("rst_cnt",   {27'd0, s_cnt}, 0);
      chk("rst_rd",    {31'd0, s_rd}, 0);

      // Full drain against the cycle table
      for (int i = 0; i < 8; i++) push_word(8'(i));
      for (int c = 0; c < 13; c++) begin
         startIn = tbl[c].start; lengthIn = tbl[c].len; outReadyIn = tbl[c].ready;
         cyc();
         chk($sformatf("drain[%0d].rd", c),    {31'd0, s_rd},    {31'd0, tbl[c].erd});
         chk($sformatf("drain[%0d].valid", c), {31'd0, s_valid}, {31'd0, tbl[c].ev});
         if (tbl[c].ev) chk($sformatf("drain[%0d].data", c), {24'd0, s_data}, {24'd0, tbl[c].ed});
         chk($sformatf("drain[%0d].done", c),  {31'd0, s_done},  {31'd0, tbl[c].edone});
         chk($sformatf("drain[%0d].busy", c),  {31'd0, s_busy},  {31'd0, tbl[c].ebusy});
         chk($sformatf("drain[%0d].cnt", c),   {27'd0, s_cnt},   {27'd0, tbl[c].ecnt});
      end

      // Backpressure: ready alternates every cycle
      for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         startIn = (i == 0); lengthIn = 5'd8; outReadyIn = ((i % 2) == 0);
         cyc();
         if (s_done) got = 1'b1;
      end
      outReadyIn = 1'b1;
      chk("bp_done", {31'd0, got}, 1);
      chk("bp_cnt", {27'd0, s_cnt}, 8);
      chk("bp_all_delivered", exp_q.size(), 0);

      // Starvation: 3 of 5 words available, then the rest arrive late
      for (int i = 0; i < 3; i++) push_word(8'h10 + 8'(i));
      r0 = reads_tot;
      startIn = 1'b1; lengthIn = 5'd5;
      for (int i = 0; i < 10; i++) cyc();
      chk("starve_cnt", {27'd0, s_cnt}, 3);
      chk("starve_busy", {31'd0, s_busy}, 1);
      chk("starve_reads", reads_tot - r0, 3);
      push_word(8'hA0); push_word(8'hA1);
      run_until_done("starve_done", 20);
      chk("starve_final_cnt", {27'd0, s_cnt}, 5);
      chk("starve_all_delivered", exp_q.size(), 0);

      // Reset mid-transfer with a read in flight
      for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
      startIn = 1'b1; lengthIn = 5'd8;
      for (int i = 0; i < 5; i++) cyc();
      rstIn = 1'b0;
      cyc(); cyc();
      rstIn = 1'b1;
      cyc();
      chk("mrst_valid", {31'd0, s_valid}, 0);
      chk("mrst_data",  {24'd0, s_data}, 0);
      chk("mrst_busy",  {31'd0, s_busy}, 0);
      chk("mrst_done",  {31'd0, s_done}, 0);
      chk("mrst_cnt",   {27'd0, s_cnt}, 0);
      chk("mrst_rd",    {31'd0, s_rd}, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("mrst_idle_valid", {31'd0, s_valid}, 0);
      end
      chk("mrst_fifo_left", fifo.size(), 4);
      exp_q = fifo;
      startIn = 1'b1; lengthIn = 5'(fifo.size());
      run_until_done("mrst_resume_done", 20);
      chk("mrst_resume_cnt", {27'd0, s_cnt}, 4);
      chk("mrst_all_delivered", exp_q.size(), 0);

      // Zero length with data waiting in the FIFO
      push_word(8'h60);
      startIn = 1'b1; lengthIn = 5'd0;
      cyc();
      chk("zero_c0_rd", {31'd0, s_rd}, 0);
      cyc();
      chk("zero_c1_done", {31'd0, s_done}, 1);
      chk("zero_c1_rd", {31'd0, s_rd}, 0);
      chk("zero_c1_busy", {31'd0, s_busy}, 0);
      cyc();
      chk("zero_c2_done", {31'd0, s_done}, 0);
      chk("zero_c2_rd", {31'd0, s_rd}, 0);
      chk("zero_cnt", {27'd0, s_cnt}, 0);

      // Start ignored while busy, then a restart of 2 words
      for (int i = 1; i < 8; i++) push_word(8'h40 + 8'(i));
      d0 = done_cnt;
      for (int i = 0; i < 16; i++) begin
         startIn = (i == 0 || i == 3);
         lengthIn = (i == 0) ? 5'd8 : 5'd3;
         cyc();
      end
      chk("ign_single_done", done_cnt - d0, 1);
      chk("ign_cnt", {27'd0, s_cnt}, 8);
      chk("ign_idle", {31'd0, s_busy}, 0);
      push_word(8'h50); push_word(8'h51); push_word(8'h52);
      startIn = 1'b1; lengthIn = 5'd2;
      cyc();
      chk("restart_c0_cnt_held", {27'd0, s_cnt}, 8);
      cyc();
      chk("restart_c1_cnt_cleared", {27'd0, s_cnt}, 0);
      run_until_done("restart_done", 20);
      chk("restart_cnt", {27'd0, s_cnt}, 2);
      chk("restart_fifo_left", fifo.size(), 1);
      chk("restart_exp_left", exp_q.size(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
